mem_access_unit: RTL and testbench

Parametrised load/store engine between the multicycle core's datapath and a variable-latency memory bus. It replaces the fixed single-cycle memory access with a request/acknowledge handshake. It adds byte-lane loads and stores, with read-modify-write for byte stores, misalignment detection and a bus timeout. The core issues one access at a time through a start/done handshake.

---
 rtl/mem_access_unit.sv | 155 +++++++++++++++
 tb/tb_mem_access_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Load/store engine with req/ack bus handshake, byte lanes,
//               read-modify-write byte stores, misalignment and bus timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              start,
    input  logic              we,
    input  logic              byte_mode,
    input  logic              sext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int c_LANES  = DATA_W / 8;
    localparam int c_LANE_W = (c_LANES > 1) ? $clog2(c_LANES) : 1;
    localparam int c_CNT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_WAIT_LAST = c_CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RD   = 2'd1;
    localparam logic [1:0] c_ST_WR   = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    logic [1:0]          r_state;
    logic                r_we;
    logic                r_byte;
    logic                r_sext;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wbuf;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic [c_CNT_W-1:0]  r_wait;

    logic [c_LANE_W-1:0] w_lane;
    logic [c_LANE_W-1:0] w_in_lane;
    logic [7:0]          w_rd_byte;
    logic [DATA_W-1:0]   w_merged;
    logic [DATA_W-1:0]   w_ext;
    logic                w_timeout;

    assign w_lane    = r_addr[c_LANE_W-1:0];
    assign w_in_lane = addr[c_LANE_W-1:0];

    // Lane extraction for byte loads and lane merge for byte stores
    always_comb begin
        w_rd_byte = '0;
        w_merged  = mem_rdata;
        for (int k = 0; k < c_LANES; k++) begin
            if (w_lane == c_LANE_W'(k)) begin
                w_rd_byte          = mem_rdata[8*k +: 8];
                w_merged[8*k +: 8] = r_wbuf[7:0];
            end
        end
    end

    assign w_ext     = {{(DATA_W-8){r_sext & w_rd_byte[7]}}, w_rd_byte};
    assign w_timeout = (TIMEOUT > 0) && (r_wait == c_WAIT_LAST) && !mem_ack;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
            r_we    <= 1'b0;
            r_byte  <= 1'b0;
            r_sext  <= 1'b0;
            r_addr  <= '0;
            r_wbuf  <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_wait  <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_we   <= we;
                        r_byte <= byte_mode;
                        r_sext <= sext;
                        r_addr <= addr;
                        r_wbuf <= wdata;
                        r_wait <= '0;
                        if (!byte_mode && (w_in_lane != '0)) begin
                            r_err   <= 1'b1;
                            r_state <= c_ST_DONE;
                        end else if (!we || byte_mode) begin
                            r_state <= c_ST_RD;
                        end else begin
                            r_state <= c_ST_WR;
                        end
                    end
                end
                c_ST_RD: begin
                    if (mem_ack) begin
                        r_wait <= '0;
                        if (r_we) begin
                            r_wbuf  <= w_merged;
                            r_state <= c_ST_WR;
                        end else begin
                            r_rdata <= r_byte ? w_ext : mem_rdata;
                            r_state <= c_ST_DONE;
                        end
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= c_ST_DONE;
                    end else begin
                        r_wait <= r_wait + c_CNT_W'(1);
                    end
                end
                c_ST_WR: begin
                    if (mem_ack) begin
                        r_state <= c_ST_DONE;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= c_ST_DONE;
                    end else begin
                        r_wait <= r_wait + c_CNT_W'(1);
                    end
                end
                c_ST_DONE: begin
                    r_err   <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign busy      = (r_state != c_ST_IDLE);
    assign done      = (r_state == c_ST_DONE);
    assign err       = r_err;
    assign rdata     = r_rdata;
    assign mem_req   = (r_state == c_ST_RD) || (r_state == c_ST_WR);
    assign mem_we    = (r_state == c_ST_WR);
    assign mem_addr  = r_addr >> c_LANE_W;
    assign mem_wdata = r_wbuf;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed self-checking bench for mem_access_unit (16-bit data).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clock;
    logic        rst;
    logic        start;
    logic        we;
    logic        byte_mode;
    logic        sext;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mem [16];
    int          ack_wait = 0;
    bit          no_ack   = 0;
    int          wcnt     = 0;
    int          wr_count = 0;
    logic [15:0] last_wr_addr = '0;
    logic [15:0] last_wr_data = '0;
    int          n_done   = 0;

    mem_access_unit #(
        .DATA_W (16),
        .ADDR_W (16),
        .TIMEOUT(4)
    ) dut (
        .clock    (clock),
        .rst      (rst),
        .start    (start),
        .we       (we),
        .byte_mode(byte_mode),
        .sext     (sext),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .rdata    (rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Bus responder: acks after ack_wait idle request cycles, updates at negedge
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        forever begin
            @(negedge clock);
            if (done) n_done++;
            mem_ack = 1'b0;
            if (mem_req && !no_ack) begin
                if (wcnt == ack_wait) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[mem_addr[3:0]];
                    if (mem_we) begin
                        mem[mem_addr[3:0]] = mem_wdata;
                        wr_count++;
                        last_wr_addr = mem_addr;
                        last_wr_data = mem_wdata;
                    end
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issues one access; returns the cycle of done (-1 if none within budget)
    task automatic run_access(input logic iwe, input logic ibm, input logic isx,
                              input logic [15:0] ia, input logic [15:0] iwd,
                              input int hold, output int dcyc, output int req_cyc,
                              output logic [15:0] req_addr);
        start = 1'b1; we = iwe; byte_mode = ibm; sext = isx; addr = ia; wdata = iwd;
        dcyc = -1; req_cyc = 0; req_addr = 16'hxxxx;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (c >= hold) start = 1'b0;
            if (mem_req) begin
                if (req_cyc == 0) req_addr = mem_addr;
                req_cyc++;
            end
            if (done) begin
                dcyc = c;
                break;
            end
        end
        start = 1'b0;
    endtask

    int          dcyc;
    int          rcyc;
    logic [15:0] raddr;
    int          snap;

    initial begin
        rst = 1'b0; start = 1'b0; we = 1'b0; byte_mode = 1'b0; sext = 1'b0;
        addr = '0; wdata = '0;
        step();
        step();
        check("rst_busy",      {31'd0, busy},    32'd0);
        check("rst_done",      {31'd0, done},    32'd0);
        check("rst_err",       {31'd0, err},     32'd0);
        check("rst_mem_req",   {31'd0, mem_req}, 32'd0);
        check("rst_mem_we",    {31'd0, mem_we},  32'd0);
        check("rst_rdata",     {16'd0, rdata},   32'd0);
        check("rst_mem_addr",  {16'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
        @(negedge clock);
        rst = 1'b1;
        step();

        // Word load
        mem[2] = 16'h1234;
        run_access(1'b0, 1'b0, 1'b0, 16'h0004, 16'h0000, 1, dcyc, rcyc, raddr);
        check("wload_addr",  {16'd0, raddr}, 32'h0002);
        check("wload_cycle", dcyc, 32'd2);
        check("wload_rdata", {16'd0, rdata}, 32'h1234);
        check("wload_err",   {31'd0, err}, 32'd0);
        step();
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_done", {31'd0, done}, 32'd0);

        // Byte store, read-modify-write of lane 1
        mem[1] = 16'h1234;
        snap = wr_count;
        run_access(1'b1, 1'b1, 1'b0, 16'h0003, 16'h00AB, 1, dcyc, rcyc, raddr);
        check("bstore_cycle",   dcyc, 32'd3);
        check("bstore_reqcyc",  rcyc, 32'd2);
        check("bstore_wraddr",  {16'd0, last_wr_addr}, 32'h0001);
        check("bstore_wrdata",  {16'd0, last_wr_data}, 32'hAB34);
        check("bstore_nwrites", wr_count - snap, 32'd1);
        check("bstore_err",     {31'd0, err}, 32'd0);
        step();

        // Byte loads with sign/zero extension
        mem[1] = 16'h0080;
        run_access(1'b0, 1'b1, 1'b1, 16'h0002, 16'h0000, 1, dcyc, rcyc, raddr);
        check("bload_sx_cycle", dcyc, 32'd2);
        check("bload_sx_rdata", {16'd0, rdata}, 32'hFF80);
        step();
        run_access(1'b0, 1'b1, 1'b0, 16'h0002, 16'h0000, 1, dcyc, rcyc, raddr);
        check("bload_zx_rdata", {16'd0, rdata}, 32'h0080);
        step();
        mem[3] = 16'h9C11;
        run_access(1'b0, 1'b1, 1'b1, 16'h0007, 16'h0000, 1, dcyc, rcyc, raddr);
        check("bload_hi_rdata", {16'd0, rdata}, 32'hFF9C);
        step();

        // Misaligned word store
        snap = wr_count;
        run_access(1'b1, 1'b0, 1'b0, 16'h0005, 16'h5555, 1, dcyc, rcyc, raddr);
        check("mis_cycle",  dcyc, 32'd1);
        check("mis_err",    {31'd0, err}, 32'd1);
        check("mis_reqcyc", rcyc, 32'd0);
        check("mis_writes", wr_count - snap, 32'd0);
        step();
        check("mis_err_clr", {31'd0, err}, 32'd0);

        // Word store with two wait cycles
        ack_wait = 2;
        run_access(1'b1, 1'b0, 1'b0, 16'h0006, 16'hBEEF, 1, dcyc, rcyc, raddr);
        check("wstore_cycle", dcyc, 32'd4);
        check("wstore_mem",   {16'd0, mem[3]}, 32'hBEEF);
        check("wstore_err",   {31'd0, err}, 32'd0);
        ack_wait = 0;
        step();

        // Timeout with no acknowledge
        no_ack = 1'b1;
        run_access(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1, dcyc, rcyc, raddr);
        check("tmo_reqcyc", rcyc, 32'd4);
        check("tmo_cycle",  dcyc, 32'd5);
        check("tmo_err",    {31'd0, err}, 32'd1);
        check("tmo_rdata",  {16'd0, rdata}, 32'hFF9C);
        check("tmo_req",    {31'd0, mem_req}, 32'd0);
        no_ack = 1'b0;
        step();

        // Reset in the second wait cycle of a load
        ack_wait = 5;
        snap = n_done;
        start = 1'b1; we = 1'b0; byte_mode = 1'b0; sext = 1'b0; addr = 16'h0004;
        step();
        start = 1'b0;
        step();
        rst = 1'b0;
        #1;
        check("midrst_req",  {31'd0, mem_req}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        step();
        step();
        check("midrst_nodone", n_done - snap, 32'd0);
        @(negedge clock);
        rst = 1'b1;
        ack_wait = 0;
        step();

        // Load after reset, with start held into the busy cycle
        snap = n_done;
        run_access(1'b0, 1'b0, 1'b0, 16'h0004, 16'h0000, 2, dcyc, rcyc, raddr);
        check("post_cycle", dcyc, 32'd2);
        check("post_rdata", {16'd0, rdata}, 32'h1234);
        for (int i = 0; i < 6; i++) step();
        check("busy_start_ignored", n_done - snap, 32'd1);
        check("post_idle", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
